// File: rtl/salamander_pkg.sv
// Shared constants and types for the salamander CPU and its program loader.
package salamander_pkg;

    // Instruction word: 3-bit opcode, 2-bit operand address, 1 spare bit
    localparam int INSTR_W = 6;
    // Program memory address width; equals the CPU program counter width
    localparam int ADDR_W  = 5;
    // Number of program memory entries; always 2**ADDR_W
    localparam int DEPTH   = 32;

    // NOP opcode; a zero word is a harmless instruction for padding
    localparam logic [2:0]         OP_NOP   = 3'b000;
    localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, 3'b000};

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FILL  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Instruction stream carrying the program image into the loader.
//
// Handshake: a word transfers on a rising clock edge where in_valid and
// in_ready are both high. in_data and in_last are only meaningful while
// in_valid is high; in_last marks the final word of the image. in_ready does
// not depend on in_valid, so the source may wait for it before asserting.
interface prog_loader_if;
    import salamander_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_data;
    logic               in_last;

    // Stream source (image provider)
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    // Stream sink (the loader)
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/prog_loader.sv
// Program memory writer: streams an image into the 32-entry program memory,
// pads the tail with a fill word and holds the CPU in reset until complete.
module prog_loader
    import salamander_pkg::*;
#(
    parameter logic [INSTR_W-1:0] FILL_WORD = NOP_WORD
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load_req,
    prog_loader_if.slave        stream,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INSTR_W-1:0]  mem_wdata,
    output logic                cpu_rstn,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [ADDR_W:0]     word_count,
    output loader_state_t       o_dbg_state
);

    // Pointer value of the final memory entry, and a width-matched increment
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    loader_state_t       r_state;
    loader_state_t       w_next_state;

    // Pointer is one bit wider than the address so it can reach DEPTH
    logic [ADDR_W:0]     r_ptr;
    logic [ADDR_W:0]     r_cnt;
    logic                r_ovf;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [INSTR_W-1:0]  r_wdata;
    logic                r_cpu_rstn;
    logic                r_done;

    logic [ADDR_W:0]     w_nxt_ptr;
    logic [ADDR_W:0]     w_nxt_cnt;
    logic                w_nxt_ovf;
    logic                w_nxt_we;
    logic [ADDR_W-1:0]   w_nxt_addr;
    logic [INSTR_W-1:0]  w_nxt_wdata;
    logic                w_nxt_cpu_rstn;
    logic                w_nxt_done;

    logic                w_in_ready;
    logic                w_hs;

    // Stream is accepted only while loading or draining excess words
    assign w_in_ready      = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    assign w_hs            = stream.in_valid && w_in_ready;
    assign stream.in_ready = w_in_ready;

    // Next state and next datapath values; every target defaulted first
    always_comb begin
        w_next_state   = r_state;
        w_nxt_ptr      = r_ptr;
        w_nxt_cnt      = r_cnt;
        w_nxt_ovf      = r_ovf;
        w_nxt_we       = 1'b0;
        w_nxt_addr     = r_addr;
        w_nxt_wdata    = r_wdata;
        w_nxt_cpu_rstn = 1'b0;
        w_nxt_done     = 1'b0;

        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (load_req) begin
                    w_next_state = ST_LOAD;
                    w_nxt_ptr    = '0;
                    w_nxt_cnt    = '0;
                    w_nxt_ovf    = 1'b0;
                end
            end

            ST_LOAD: begin
                if (w_hs) begin
                    w_nxt_we    = 1'b1;
                    w_nxt_addr  = r_ptr[ADDR_W-1:0];
                    w_nxt_wdata = stream.in_data;
                    w_nxt_ptr   = r_ptr + ONE;
                    w_nxt_cnt   = r_cnt + ONE;
                    if (stream.in_last) begin
                        w_next_state = (r_ptr == LAST_PTR) ? ST_RUN : ST_FILL;
                    end else if (r_ptr == LAST_PTR) begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // Excess words are swallowed so the source can finish its image
                if (w_hs) begin
                    w_nxt_ovf = 1'b1;
                    if (stream.in_last) begin
                        w_next_state = ST_ERROR;
                    end
                end
            end

            ST_FILL: begin
                w_nxt_we    = 1'b1;
                w_nxt_addr  = r_ptr[ADDR_W-1:0];
                w_nxt_wdata = FILL_WORD;
                w_nxt_ptr   = r_ptr + ONE;
                if (r_ptr == LAST_PTR) begin
                    w_next_state = ST_RUN;
                end
            end

            ST_RUN: begin
                // RUN is entered as the final write is presented, so the CPU
                // release lands one cycle later and never overlaps a write
                if (load_req) begin
                    w_next_state = ST_LOAD;
                    w_nxt_ptr    = '0;
                    w_nxt_cnt    = '0;
                    w_nxt_ovf    = 1'b0;
                end else begin
                    w_nxt_cpu_rstn = 1'b1;
                    w_nxt_done     = 1'b1;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pointer, counters, flags and the registered memory write port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cpu_rstn <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ptr      <= w_nxt_ptr;
            r_cnt      <= w_nxt_cnt;
            r_ovf      <= w_nxt_ovf;
            r_we       <= w_nxt_we;
            r_addr     <= w_nxt_addr;
            r_wdata    <= w_nxt_wdata;
            r_cpu_rstn <= w_nxt_cpu_rstn;
            r_done     <= w_nxt_done;
        end
    end

    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign cpu_rstn    = r_cpu_rstn;
    assign done        = r_done;
    assign overflow    = r_ovf;
    assign word_count  = r_cnt;
    assign busy        = (r_state == ST_LOAD) || (r_state == ST_DRAIN) ||
                         (r_state == ST_FILL);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: image table, randomized images and
// hand-written reset/abort sequences, checked against an image-level model.
module tb_prog_loader;
  import salamander_pkg::*;

  logic                clk;
  logic                rstn;
  logic                load_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [INSTR_W-1:0]  mem_wdata;
  logic                cpu_rstn;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [ADDR_W:0]     word_count;
  loader_state_t       dut_state;

  prog_loader_if bus ();

  prog_loader dut (
    .clk         (clk),
    .rstn        (rstn),
    .load_req    (load_req),
    .stream      (bus),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_rstn    (cpu_rstn),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .word_count  (word_count),
    .o_dbg_state (dut_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Image under test and expected memory contents
  logic [INSTR_W-1:0] img_q[$];
  int                 gap_q[$];
  logic [INSTR_W-1:0] exp_q[$];

  // Observed traffic
  logic [ADDR_W-1:0]  wr_addr_q[$];
  logic [INSTR_W-1:0] wr_data_q[$];
  int                 wr_cyc_q[$];
  int                 hs_cyc_q[$];
  int                 rise_cyc;
  bit                 rise_seen;
  logic               prev_cpu_rstn = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        wr_cyc_q.push_back(cyc);
        chk("we_with_cpu_released", {31'b0, cpu_rstn}, 32'd0);
      end
      if (bus.in_valid && bus.in_ready) hs_cyc_q.push_back(cyc);
      if (cpu_rstn && !prev_cpu_rstn) begin
        rise_seen = 1'b1;
        rise_cyc  = cyc;
      end
    end
    prev_cpu_rstn = cpu_rstn;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  task automatic send_word(input logic [INSTR_W-1:0] d, input logic last);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!ok && t < 100) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Load img_q (with gap_q idle cycles after each word) and score the result
  task automatic run_image(input string tag, input int exp_cnt, input bit exp_ovf, input bit exp_run);
    int n;
    int n_mem;
    int t;
    n = img_q.size();
    n_mem = (n > DEPTH) ? DEPTH : n;

    // Model: first DEPTH stream words, remaining entries padded
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back((i < n) ? img_q[i] : NOP_WORD);

    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    hs_cyc_q.delete();
    rise_seen = 1'b0;

    pulse_load();
    chk({tag, ".start_cpu_rstn"}, {31'b0, cpu_rstn}, 32'd0);
    chk({tag, ".start_done"}, {31'b0, done}, 32'd0);
    chk({tag, ".start_count"}, 32'(word_count), 32'd0);
    chk({tag, ".start_ovf"}, {31'b0, overflow}, 32'd0);
    chk({tag, ".start_busy"}, {31'b0, busy}, 32'd1);

    for (int i = 0; i < n; i++) begin
      send_word(img_q[i], i == n - 1);
      if (i != n - 1) repeat (gap_q[i]) begin
        @(posedge clk);
        #1;
      end
    end

    t = 0;
    while (!(cpu_rstn || dut_state == ST_ERROR) && t < 80) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 80) chk({tag, ".complete_timeout"}, 32'd0, 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    chk({tag, ".n_writes"}, wr_addr_q.size(), DEPTH);
    chk({tag, ".accepted"}, hs_cyc_q.size(), n);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < wr_addr_q.size())
        chk({tag, $sformatf(".wr%0d", i)}, {21'b0, wr_addr_q[i], wr_data_q[i]},
            {21'b0, 5'(i), exp_q[i]});
    end
    for (int i = 0; i < n_mem; i++) begin
      if (i < wr_cyc_q.size() && i < hs_cyc_q.size())
        chk({tag, $sformatf(".lat%0d", i)}, wr_cyc_q[i] - hs_cyc_q[i], 32'd1);
    end
    for (int i = n_mem; i < DEPTH; i++) begin
      if (i > 0 && i < wr_cyc_q.size())
        chk({tag, $sformatf(".fill_gap%0d", i)}, wr_cyc_q[i] - wr_cyc_q[i-1], 32'd1);
    end

    chk({tag, ".word_count"}, 32'(word_count), exp_cnt);
    chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, exp_ovf});
    chk({tag, ".done"}, {31'b0, done}, {31'b0, exp_run});
    chk({tag, ".cpu_rstn"}, {31'b0, cpu_rstn}, {31'b0, exp_run});
    chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
    chk({tag, ".state"}, 32'(dut_state), exp_run ? 32'(ST_RUN) : 32'(ST_ERROR));
    if (exp_run) begin
      if (rise_seen && wr_cyc_q.size() > 0)
        chk({tag, ".release_cycle"}, rise_cyc - wr_cyc_q[wr_cyc_q.size()-1], 32'd1);
      else
        chk({tag, ".release_seen"}, {31'b0, rise_seen}, 32'd1);
    end else begin
      chk({tag, ".no_release"}, {31'b0, rise_seen}, 32'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n;        // words in the image
    int gap;      // idle cycles between words; negative = random 0..2
    int pat;      // 0: 05,2A,11   1: data = index   2: random data
    int exp_cnt;
    bit exp_ovf;
    bit exp_run;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{n: 3,  gap: 0,  pat: 0, exp_cnt: 3,  exp_ovf: 1'b0, exp_run: 1'b1};
    vecs[1] = '{n: 3,  gap: 2,  pat: 0, exp_cnt: 3,  exp_ovf: 1'b0, exp_run: 1'b1};
    vecs[2] = '{n: 32, gap: 0,  pat: 1, exp_cnt: 32, exp_ovf: 1'b0, exp_run: 1'b1};
    vecs[3] = '{n: 34, gap: 0,  pat: 1, exp_cnt: 32, exp_ovf: 1'b1, exp_run: 1'b0};
    vecs[4] = '{n: 1,  gap: 0,  pat: 2, exp_cnt: 1,  exp_ovf: 1'b0, exp_run: 1'b1};
    vecs[5] = '{n: 31, gap: 1,  pat: 2, exp_cnt: 31, exp_ovf: 1'b0, exp_run: 1'b1};
    vecs[6] = '{n: 33, gap: -1, pat: 2, exp_cnt: 32, exp_ovf: 1'b1, exp_run: 1'b0};
    vecs[7] = '{n: 32, gap: -1, pat: 2, exp_cnt: 32, exp_ovf: 1'b0, exp_run: 1'b1};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [INSTR_W-1:0] short_img [3];
    int n;
    short_img[0] = 6'h05;
    short_img[1] = 6'h2A;
    short_img[2] = 6'h11;

    rstn         = 1'b0;
    load_req     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // Reset: outputs quiet while held and after release
    #10;
    chk("rst.cpu_rstn_held", {31'b0, cpu_rstn}, 32'd0);
    chk("rst.mem_we_held", {31'b0, mem_we}, 32'd0);
    #10;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst.mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst.cpu_rstn", {31'b0, cpu_rstn}, 32'd0);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.overflow", {31'b0, overflow}, 32'd0);
    chk("rst.word_count", 32'(word_count), 32'd0);
    chk("rst.in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst.state", 32'(dut_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;

    // load_req together with a valid word in IDLE: the word is not taken
    load_req     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 6'h3F;
    @(negedge clk);
    chk("idle.in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    load_req     = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("idle.state_load", 32'(dut_state), 32'(ST_LOAD));
    chk("idle.no_word", 32'(word_count), 32'd0);
    chk("idle.no_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1;

    // Mid-load load_req is ignored; async reset aborts instantly
    for (int i = 0; i < 3; i++) send_word(6'($urandom_range(0, 63)), 1'b0);
    chk("abort.count3", 32'(word_count), 32'd3);
    pulse_load();
    chk("abort.req_ignored_count", 32'(word_count), 32'd3);
    chk("abort.req_ignored_state", 32'(dut_state), 32'(ST_LOAD));
    send_word(6'h2B, 1'b0);
    chk("abort.we_before", {31'b0, mem_we}, 32'd1);
    chk("abort.addr_before", {26'b0, mem_addr, mem_wdata}, {26'b0, 5'd3, 6'h2B});
    rstn = 1'b0;
    #1;
    chk("abort.we_dropped", {31'b0, mem_we}, 32'd0);
    chk("abort.busy_dropped", {31'b0, busy}, 32'd0);
    chk("abort.cpu_rstn", {31'b0, cpu_rstn}, 32'd0);
    chk("abort.state", 32'(dut_state), 32'(ST_IDLE));
    chk("abort.count", 32'(word_count), 32'd0);
    #20;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven images (RUN/ERROR states chain into reloads)
    for (int v = 0; v < 8; v++) begin
      img_q.delete();
      gap_q.delete();
      for (int i = 0; i < vecs[v].n; i++) begin
        case (vecs[v].pat)
          0:       img_q.push_back(short_img[i % 3]);
          1:       img_q.push_back(6'(i));
          default: img_q.push_back(6'($urandom_range(0, 63)));
        endcase
        gap_q.push_back((vecs[v].gap < 0) ? int'($urandom_range(0, 2)) : vecs[v].gap);
      end
      run_image($sformatf("vec%0d", v), vecs[v].exp_cnt, vecs[v].exp_ovf, vecs[v].exp_run);
    end

    // Randomized images scored by the model
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, DEPTH + 4);
      img_q.delete();
      gap_q.delete();
      for (int i = 0; i < n; i++) begin
        img_q.push_back(6'($urandom_range(0, 63)));
        gap_q.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      run_image($sformatf("rnd%0d", r), (n > DEPTH) ? DEPTH : n, n > DEPTH, n <= DEPTH);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the run is far shorter than this
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the CPU program memory. The CPU fetch path only reads that memory; this block fills it.
- Accepts a valid/ready stream of 6-bit instruction words and writes them sequentially into the 32-entry program memory.
- Pads unused entries with a fill word.
- Holds CPU_toplevel in reset while loading and releases it when the image is complete.

Parameters:
- INSTR_W, 6, instruction width (3-bit opcode + 2-bit addr + 1 spare)
- ADDR_W, 5, program memory address width (matches the PC width)
- DEPTH, 32, number of program memory entries; must equal 2**ADDR_W
- FILL_WORD, 6'b000000, value written to entries not supplied by the stream

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- load_req  in  1  one-cycle pulse; starts a load from IDLE, RUN or ERROR
- in_valid  in  1  stream word valid
- in_ready  out  1  stream word accepted when in_valid && in_ready
- in_data  in  INSTR_W  instruction word
- in_last  in  1  marks final word of the image; qualified by the handshake
- mem_we  out  1  program memory write enable
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  INSTR_W  write data
- cpu_rstn  out  1  active-low reset to the CPU; 0 = CPU held
- busy  out  1  high in LOAD, DRAIN and FILL
- done  out  1  high in RUN
- overflow  out  1  sticky; stream exceeded DEPTH words
- word_count  out  ADDR_W+1  words accepted into memory, excluding fill and discarded words

Behaviour:
- Reset (async, rstn=0): state IDLE; all outputs 0, including cpu_rstn=0 (CPU held) and word_count=0; internal pointer 0.
- States: IDLE, LOAD, DRAIN, FILL, RUN, ERROR.
- IDLE, RUN or ERROR, load_req=1 → LOAD next cycle:
  - pointer := 0, word_count := 0, overflow := 0, done := 0;
  - cpu_rstn := 0 on that same edge.
- load_req is ignored in LOAD, DRAIN and FILL.
- LOAD:
  - in_ready=1 combinationally.
  - Each handshake registers mem_we=1, mem_addr=pointer, mem_wdata=in_data on the next edge, so the write is visible one cycle after the handshake.
  - The same edge increments pointer and word_count.
  - No handshake in a cycle → mem_we=0 next cycle.
- LOAD exits:
  - in_last with pointer<DEPTH-1 → FILL.
  - in_last with pointer==DEPTH-1 → RUN.
  - Handshake at pointer==DEPTH-1 without in_last → DRAIN.
- DRAIN:
  - in_ready=1; accepted words are discarded, with no mem_we.
  - overflow := 1 on the first discarded word.
  - Handshake with in_last → ERROR.
- FILL:
  - in_ready=0.
  - One write per cycle of FILL_WORD at pointer, pointer+1, …, DEPTH-1, on consecutive cycles.
  - The first fill write is on the cycle directly after the last stream write; no gap.
  - After the DEPTH-1 write is registered → RUN.
- RUN:
  - cpu_rstn=1 and done=1, both registered.
  - They assert on the cycle after the final memory write (stream or fill); mem_we is never high at the same time as cpu_rstn.
  - in_ready=0.
- ERROR:
  - cpu_rstn stays 0; done=0; overflow=1; in_ready=0.
  - Memory holds the first DEPTH words.
- Pointer never wraps. Writes only ever target addresses 0..DEPTH-1, each exactly once per load.
- Simultaneous in_valid and load_req in IDLE: the word is not accepted, because in_ready=0 until LOAD.
- Async reset mid-load: immediate return to IDLE; mem_we drops asynchronously; partial memory contents are undefined for the next load.

Decomposition:
- Shared package salamander_pkg holds:
  - INSTR_W, ADDR_W, DEPTH;
  - NOP opcode constant, used as the default FILL_WORD;
  - the loader_state_t enum (IDLE, LOAD, DRAIN, FILL, RUN, ERROR).
- CPU_toplevel uses the same width constants.
- No sub-module: one FSM, one pointer counter, one registered write port.

Test Plan:
1. Reset: rstn=0 for 20 ns then release, no stimulus → all outputs 0, cpu_rstn=0, state IDLE.
2. Short image: load_req, then continuous 6'h05, 6'h2A, 6'h11 with in_last on 6'h11 →
   - writes at addr 0,1,2 with those values, then FILL_WORD at 3..31;
   - 32 consecutive mem_we cycles;
   - cpu_rstn=1 and done=1 the cycle after the addr-31 write;
   - word_count=3.
3. Backpressure: same 3 words with in_valid low for 2 cycles between words → no mem_we in gap cycles, addresses contiguous 0,1,2, final memory identical to test 2.
4. Full image: 32 words (data = index), in_last on the 32nd → no fill writes, overflow=0, word_count=32, RUN the cycle after the addr-31 write.
5. Overflow: 34 words, in_last on the 34th → only addr 0..31 written; words 33–34 accepted (in_ready=1) but not written; overflow=1; state ERROR; cpu_rstn stays 0.
6. Reload and abort:
   - load_req in RUN → cpu_rstn=0 next cycle, new image loaded.
   - load_req pulsed mid-LOAD → ignored.
   - rstn=0 mid-LOAD → mem_we, busy and cpu_rstn drop immediately, state IDLE.
